instruction_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_perf_counters.sv | 48 ++++
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, types and the IF/ID bundle for the instruction fetch stage.
package fetch_pkg;

  localparam int DATA_WIDTH    = 20;
  localparam int ADDRESS_WIDTH = 8;
  localparam int MEM_SIZE      = 256;

  typedef logic [ADDRESS_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]    instr_t;

  typedef struct packed {
    logic   valid;
    addr_t  pc;
    instr_t instr;
  } fetch_pkt_t;

  // Word-address increment; wraps silently modulo 2^ADDRESS_WIDTH.
  function automatic addr_t pc_inc(input addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/stall event counters for the fetch stage (built only with FETCH_PERF_EN).
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall_cycles
);

  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stalls_q,  stalls_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Next-count selection with saturation.
  always_comb begin
    fetched_d = fetched_q;
    stalls_d  = stalls_q;
    if (fetch_inc) begin
      fetched_d = sat_inc(fetched_q);
    end else begin
      fetched_d = fetched_q;
    end
    if (stall_inc) begin
      stalls_d = sat_inc(stalls_q);
    end else begin
      stalls_d = stalls_q;
    end
  end

  // Counter registers, synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= 32'd0;
      stalls_q  <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      stalls_q  <= stalls_d;
    end
  end

  assign perf_fetched      = fetched_q;
  assign perf_stall_cycles = stalls_q;

endmodule

// File: rtl/instruction_fetch.sv
// PC owner and 1-cycle-latency memory initiator feeding IF/ID; handles stall and redirect.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall_cycles outputs.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_instr,
  output logic                     if_valid,
  output logic [ADDRESS_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0]    if_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall_cycles
`endif
);

  addr_t      pc_q, pc_d;
  logic       f2_valid_q, f2_valid_d;
  addr_t      f2_pc_q, f2_pc_d;
  fetch_pkt_t if_q, if_d;

  // Address to memory; a stall replays the in-flight read so mem_instr keeps M[f2_pc].
  always_comb begin
    mem_addr = pc_q;
    if (redirect_valid) begin
      mem_addr = redirect_pc;
    end else if (stall) begin
      mem_addr = f2_pc_q;
    end else begin
      mem_addr = pc_q;
    end
  end

  // Next-state: redirect squashes the in-flight word, stall holds, otherwise advance.
  always_comb begin
    pc_d       = pc_q;
    f2_valid_d = f2_valid_q;
    f2_pc_d    = f2_pc_q;
    if_d       = if_q;
    if (redirect_valid) begin
      pc_d       = pc_inc(redirect_pc);
      f2_valid_d = 1'b1;
      f2_pc_d    = redirect_pc;
      if_d.valid = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      if_d.valid = f2_valid_q;
      if_d.pc    = f2_pc_q;
      if_d.instr = mem_instr;
      f2_valid_d = 1'b1;
      f2_pc_d    = pc_q;
      pc_d       = pc_inc(pc_q);
    end
  end

  // Fetch state registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      f2_valid_q <= 1'b0;
      f2_pc_q    <= '0;
      if_q       <= '0;
    end else begin
      pc_q       <= pc_d;
      f2_valid_q <= f2_valid_d;
      f2_pc_q    <= f2_pc_d;
      if_q       <= if_d;
    end
  end

  assign if_valid = if_q.valid;
  assign if_pc    = if_q.pc;
  assign if_instr = if_q.instr;

`ifdef FETCH_PERF_EN
  logic fetch_inc;
  logic stall_inc;

  assign fetch_inc = !redirect_valid && !stall && f2_valid_q;
  assign stall_inc = stall && !redirect_valid;

  fetch_perf_counters u_perf (
    .clk               (clk),
    .rst_n             (rst_n),
    .fetch_inc         (fetch_inc),
    .stall_inc         (stall_inc),
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
  );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch with a 1-cycle-latency memory model.
module tb_instruction_fetch;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic         redirect_valid;
  logic [7:0]   redirect_pc;
  logic [7:0]   mem_addr;
  logic [19:0]  mem_instr;
  logic         if_valid;
  logic [7:0]   if_pc;
  logic [19:0]  if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_fetched;
  logic [31:0]  perf_stall_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [19:0] mem [0:MEM_SIZE-1];

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, preloaded with A0000|i.
  always @(posedge clk) mem_instr <= mem[mem_addr];

  instruction_fetch dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .mem_addr          (mem_addr),
    .mem_instr         (mem_instr),
    .if_valid          (if_valid),
    .if_pc             (if_pc),
    .if_instr          (if_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  typedef struct {
    logic        stall;
    logic        rv;
    logic [7:0]  rpc;
    logic [7:0]  exp_addr;
    logic        exp_valid;
    logic [7:0]  exp_pc;
    logic [19:0] exp_instr;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic [7:0] rp,
                              input logic [7:0] a, input logic v, input logic [7:0] p);
    vec_t t;
    t.stall     = s;
    t.rv        = r;
    t.rpc       = rp;
    t.exp_addr  = a;
    t.exp_valid = v;
    t.exp_pc    = p;
    t.exp_instr = 20'hA0000 | {12'h000, p};
    return t;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_pc"},    {24'd0, if_pc},    32'd0);
    chk({tag, "_instr"}, {12'd0, if_instr}, 32'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_fetched"}, perf_fetched,      32'd0);
    chk({tag, "_perf_stalls"},  perf_stall_cycles, 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 20'hA0000 | 20'(i);

    // Stream, 3-cycle stall at if_pc=4, redirect 40, redirect+stall to 10, wrap at FE.
    vecs[0]  = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    vecs[1]  = mk(1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 8'h00);
    vecs[2]  = mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h01);
    vecs[3]  = mk(1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 8'h02);
    vecs[4]  = mk(1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 8'h03);
    vecs[5]  = mk(1'b0, 1'b0, 8'h00, 8'h05, 1'b1, 8'h04);
    vecs[6]  = mk(1'b1, 1'b0, 8'h00, 8'h05, 1'b1, 8'h04);
    vecs[7]  = mk(1'b1, 1'b0, 8'h00, 8'h05, 1'b1, 8'h04);
    vecs[8]  = mk(1'b1, 1'b0, 8'h00, 8'h05, 1'b1, 8'h04);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 8'h06, 1'b1, 8'h05);
    vecs[10] = mk(1'b0, 1'b0, 8'h00, 8'h07, 1'b1, 8'h06);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 8'h07);
    vecs[12] = mk(1'b0, 1'b1, 8'h40, 8'h40, 1'b0, 8'h07);
    vecs[13] = mk(1'b0, 1'b0, 8'h00, 8'h41, 1'b1, 8'h40);
    vecs[14] = mk(1'b0, 1'b0, 8'h00, 8'h42, 1'b1, 8'h41);
    vecs[15] = mk(1'b1, 1'b1, 8'h10, 8'h10, 1'b0, 8'h41);
    vecs[16] = mk(1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 8'h41);
    vecs[17] = mk(1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 8'h10);
    vecs[18] = mk(1'b0, 1'b0, 8'h00, 8'h12, 1'b1, 8'h11);
    vecs[19] = mk(1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 8'h11);
    vecs[20] = mk(1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 8'hFE);
    vecs[21] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF);
    vecs[22] = mk(1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 8'h00);
    vecs[23] = mk(1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 8'h01);

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_mem_addr", i), {24'd0, mem_addr}, {24'd0, vecs[i].exp_addr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_if_pc", i),    {24'd0, if_pc},    {24'd0, vecs[i].exp_pc});
        chk($sformatf("v%0d_if_instr", i), {12'd0, if_instr}, {12'd0, vecs[i].exp_instr});
      end
      @(negedge clk);
    end

`ifdef FETCH_PERF_EN
    // 16 advance edges with a read in flight; 4 stall edges without redirect.
    chk("perf_fetched", perf_fetched, 32'd16);
    chk("perf_stall_cycles", perf_stall_cycles, 32'd4);
`endif

    // Reset while stalled: all state clears.
    stall = 1'b1; redirect_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("rst_mid_stall");

    // Reset during a redirect: reset wins.
    @(negedge clk);
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h80;
    @(posedge clk); #1;
    check_reset_state("rst_mid_redirect");
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);

    // Release again: first valid word only after the second edge.
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_edge1_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk); #1;
    chk("rel_bubble_stall_valid", {31'd0, if_valid}, 32'd0);
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("rel_edge2_valid", {31'd0, if_valid}, 32'd1);
    chk("rel_edge2_pc",    {24'd0, if_pc},    32'd0);
    chk("rel_edge2_instr", {12'd0, if_instr}, 32'h000A0000);
    @(posedge clk); #1;
    chk("rel_edge3_pc",    {24'd0, if_pc},    32'd1);
    chk("rel_edge3_instr", {12'd0, if_instr}, 32'h000A0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
